// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared FSM state type and PC arithmetic constants for pc_sequencer
package pc_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_STALL,
        S_HALT
    } pc_state_e;

    localparam logic [31:0] PC_INCR    = 32'd4;
    localparam int          WORD_SHIFT = 2;

endpackage

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - combinational next-pc priority select (jr > jump > branch > pc+4)
module next_pc_mux
    import pc_pkg::*;
(
    input  logic [31:0] pc_plus_4,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [31:0] jump_pc,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        redirect
);

    logic [31:0] branch_target;

    // Word offset scaled to bytes; the sum wraps modulo 2^32.
    assign branch_target = pc_plus_4 + (branch_offset << WORD_SHIFT);

    always_comb begin
        next_pc  = pc_plus_4;
        redirect = 1'b0;
        if (jr) begin
            next_pc  = jr_target;
            redirect = 1'b1;
        end else if (jump) begin
            next_pc  = jump_pc;
            redirect = 1'b1;
        end else if (branch_taken) begin
            next_pc  = branch_target;
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - pc register, run/stall/halt FSM and retired count; PC_ALIGN_CHECK_EN adds misaligned-target trap
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             branch_taken,
    input  logic [31:0]      branch_offset,
    input  logic             jump,
    input  logic [31:0]      jump_pc,
    input  logic             jr,
    input  logic [31:0]      jr_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus_4,
    output logic             pc_valid,
    output logic             halted,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misaligned,
`endif
    output logic [CNT_W-1:0] instr_count
);

    pc_state_e        state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      target;
    logic             redirect;
    logic             advance;
`ifdef PC_ALIGN_CHECK_EN
    logic             mis_q, mis_d;
`endif

    assign pc_plus_4 = pc_q + PC_INCR;

    next_pc_mux u_next_pc_mux (
        .pc_plus_4     (pc_plus_4),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_pc       (jump_pc),
        .jr            (jr),
        .jr_target     (jr_target),
        .next_pc       (target),
        .redirect      (redirect)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        advance = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            S_BOOT:  state_d = S_RUN;
            S_RUN: begin
                if (halt_req)   state_d = S_HALT;
                else if (stall) state_d = S_STALL;
                else            advance = 1'b1;
            end
            S_STALL: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (!stall) begin
                    state_d = S_RUN;
                    advance = 1'b1;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase

        if (advance) begin
`ifdef PC_ALIGN_CHECK_EN
            // A bad redirect traps: pc keeps the last good address, nothing retires.
            if (redirect && (target[1:0] != 2'b00)) begin
                state_d = S_HALT;
                mis_d   = 1'b1;
            end else begin
                pc_d  = target;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
`else
            pc_d  = redirect ? {target[31:2], 2'b00} : target;
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
`ifdef PC_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
`ifdef PC_ALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign pc_valid    = (state_q == S_RUN) || (state_q == S_STALL);
    assign halted      = (state_q == S_HALT);
    assign instr_count = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misaligned  = mis_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer (honours PC_ALIGN_CHECK_EN)
module tb_pc_sequencer;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, halt_req, branch_taken, jump, jr;
    logic [31:0] branch_offset, jump_pc, jr_target;
    logic [31:0] pc, pc_plus_4, instr_count;
    logic        pc_valid, halted, misaligned;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_VECTOR(RV), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .halt_req      (halt_req),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_pc       (jump_pc),
        .jr            (jr),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_plus_4     (pc_plus_4),
        .pc_valid      (pc_valid),
        .halted        (halted),
`ifdef PC_ALIGN_CHECK_EN
        .misaligned    (misaligned),
`endif
        .instr_count   (instr_count)
    );
`ifndef PC_ALIGN_CHECK_EN
    assign misaligned = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        halted;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: the sequencer's architectural state after each edge.
    logic [31:0] m_pc, m_cnt;
    bit          m_boot, m_halt, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0] t;
        bit          redir;
        if (reset) begin
            m_pc = RV; m_cnt = 0; m_boot = 1; m_halt = 0; m_mis = 0;
        end else if (m_halt) begin
            // frozen until reset
        end else if (m_boot) begin
            m_boot = 0;
        end else if (halt_req) begin
            m_halt = 1;
        end else if (!stall) begin
            redir = jr || jump || branch_taken;
            if (jr)                t = jr_target;
            else if (jump)         t = jump_pc;
            else if (branch_taken) t = m_pc + 32'd4 + branch_offset * 32'd4;
            else                   t = m_pc + 32'd4;
            if (ALIGN && redir && (t % 4 != 0)) begin
                m_halt = 1;
                m_mis  = 1;
            end else begin
                m_pc  = t & 32'hFFFF_FFFC;
                m_cnt = m_cnt + 32'd1;
            end
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        model_edge();
        e.pc     = m_pc;
        e.valid  = !m_boot && !m_halt;
        e.halted = m_halt;
        e.cnt    = m_cnt;
        e.mis    = m_mis;
        sb.push_back(e);
        #1;
    endtask

    task automatic idle();
        reset = 0; stall = 0; halt_req = 0; branch_taken = 0; jump = 0; jr = 0;
        branch_offset = 0; jump_pc = 0; jr_target = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc", pc, e.pc);
                chk("pc_plus_4", pc_plus_4, e.pc + 32'd4);
                chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.valid});
                chk("halted", {31'd0, halted}, {31'd0, e.halted});
                chk("instr_count", instr_count, e.cnt);
                if (ALIGN) chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : driver
        idle();
        reset = 1;
        step();
        chk("t1_boot_pc", pc, 32'h0);
        chk("t1_boot_valid", {31'd0, pc_valid}, 32'd0);
        reset = 0;
        step(); chk("t1_pc0", pc, 32'h0); chk("t1_cnt0", instr_count, 32'd0);
        step(); chk("t1_pc4", pc, 32'h4); chk("t1_cnt1", instr_count, 32'd1);
        step(); chk("t1_pc8", pc, 32'h8); chk("t1_cnt2", instr_count, 32'd2);

        jump = 1; jump_pc = 32'h100;
        step(); chk("t2_pc100", pc, 32'h100);
        idle(); branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
        step(); chk("t2_branch_back", pc, 32'hFC);
        idle(); jump = 1; jump_pc = 32'h800; jr = 1; jr_target = 32'h400;
        step(); chk("t2_jr_wins", pc, 32'h400);

        idle(); jump = 1; jump_pc = 32'h8000; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_stall_pc", pc, 32'h400);
            chk("t3_stall_cnt", instr_count, 32'd5);
        end
        stall = 0;
        step(); chk("t3_release_pc", pc, 32'h8000); chk("t3_release_cnt", instr_count, 32'd6);

        idle(); jump = 1; jump_pc = 32'hFFFF_FFFC;
        step(); chk("t4_top", pc, 32'hFFFF_FFFC);
        chk("t4_wrap_p4", pc_plus_4, 32'h0);
        idle();
        step(); chk("t4_wrap_pc", pc, 32'h0); chk("t4_wrap_cnt", instr_count, 32'd8);

        jr = 1; jr_target = 32'h402;
        step();
        if (ALIGN) begin
            chk("t6_hold_pc", pc, 32'h0);
            chk("t6_mis", {31'd0, misaligned}, 32'd1);
            chk("t6_halted", {31'd0, halted}, 32'd1);
        end else begin
            chk("t6_forced_pc", pc, 32'h400);
        end
        idle(); reset = 1; step(); reset = 0; step();

        halt_req = 1; stall = 1; jump = 1; jump_pc = 32'h40;
        step();
        chk("t5_halted", {31'd0, halted}, 32'd1);
        chk("t5_valid", {31'd0, pc_valid}, 32'd0);
        chk("t5_pc", pc, 32'h0);
        idle(); jump = 1; jump_pc = 32'h40;
        step(); step();
        chk("t5_frozen", pc, 32'h0);
        idle(); reset = 1;
        step();
        chk("t5_reset_pc", pc, RV);
        chk("t5_reset_halted", {31'd0, halted}, 32'd0);
        reset = 0;

        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 39) == 0);
            halt_req      = ($urandom_range(0, 29) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            jr            = ($urandom_range(0, 5) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 4) == 0);
            branch_offset = $urandom_range(0, 1) ? $urandom : ($urandom & 32'hFF) - 32'h80;
            jump_pc       = $urandom;
            jr_target     = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                jump_pc[1:0]   = 2'b00;
                jr_target[1:0] = 2'b00;
            end
            step();
        end
        idle();
        step();
        @(negedge clk); #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
